// File: rtl/ber_pkg.sv
// Shared definitions for the PRBS BER checker: state encodings, tap table, seed length.
package ber_pkg;

  typedef enum logic [1:0] {
    ST_SEED  = 2'd0,
    ST_HUNT  = 2'd1,
    ST_CHECK = 2'd2,
    ST_LOCK  = 2'd3
  } ber_state_e;

  // Second feedback tap M for a PRBS of order N (b[n] = b[n-N] ^ b[n-M]).
  function automatic int unsigned prbs_tap(input int unsigned n);
    case (n)
      7:       return 6;
      15:      return 14;
      23:      return 18;
      31:      return 28;
      default: return 6;
    endcase
  endfunction

  // Two bits arrive per cycle, so ceil(N/2) cycles fill the history.
  function automatic int unsigned seed_len(input int unsigned n);
    return (n + 1) / 2;
  endfunction

endpackage

// File: rtl/prbs_predict2.sv
// Two-bit PRBS predictor: next two expected bits and both candidate next histories.
module prbs_predict2 #(
  parameter int unsigned N = 7,
  parameter int unsigned M = 6
) (
  input  logic [N-1:0] h_i,
  input  logic [1:0]   din_i,
  output logic [1:0]   pred_c,
  output logic [N-1:0] h_seed_c,
  output logic [N-1:0] h_pred_c
);

  // h_i[0] is the newest bit; pred_c[1] is the earlier of the two predicted bits.
  assign pred_c   = {h_i[N-1] ^ h_i[M-1], h_i[N-2] ^ h_i[M-2]};
  assign h_seed_c = {h_i[N-3:0], din_i};
  assign h_pred_c = {h_i[N-3:0], pred_c};

endmodule

// File: rtl/prbs_ber_checker.sv
// Receive-side PRBS BER checker, 2 bits/cycle. Define PRBS_LOCK_EN for the HUNT/LOCK flow.
module prbs_ber_checker
  import ber_pkg::*;
#(
  parameter int unsigned PRBS_N = 7,
  parameter int unsigned RECV_W = 58,
  parameter int unsigned ERR_W  = 64
`ifdef PRBS_LOCK_EN
  ,
  parameter int unsigned LOCK_CNT = 64,
  parameter int unsigned LOSS_CNT = 16
`endif
) (
  input  logic              CLK,
  input  logic              RSTX,
  input  logic              CLR,
  input  logic              EN,
  input  logic [1:0]        DIN,
  output logic [RECV_W-1:0] RECV_CNT,
  output logic [ERR_W-1:0]  ERR_CNT,
  output logic              LOCKED,
  output logic              SAT
);

  localparam int unsigned TAP_M    = prbs_tap(PRBS_N);
  localparam int unsigned SEED_LEN = seed_len(PRBS_N);
  localparam int unsigned SEED_W   = $clog2(SEED_LEN + 1);
  localparam int unsigned ERR_SW   = ERR_W + 1;
  localparam logic [RECV_W-1:0] RECV_MAX = '1;
  localparam logic [ERR_W-1:0]  ERR_MAX  = '1;
`ifdef PRBS_LOCK_EN
  localparam int unsigned RUN_W  = $clog2(LOCK_CNT + 1);
  localparam int unsigned LOSS_W = $clog2(LOSS_CNT + 1);
`endif

  ber_state_e        state_q, state_d;
  logic [1:0]        din_q, din_d;
  logic              en_q, en_d;
  logic [PRBS_N-1:0] h_q, h_d;
  logic [SEED_W-1:0] seed_q, seed_d;
  logic [RECV_W-1:0] recv_q, recv_d;
  logic [ERR_W-1:0]  err_q, err_d;
  logic              sat_q, sat_d;
  logic              locked_q, locked_d;
`ifdef PRBS_LOCK_EN
  logic [RUN_W-1:0]  run_q, run_d;
  logic [LOSS_W-1:0] loss_q, loss_d;
`endif

  logic [1:0]        pred_c;
  logic [1:0]        miss_c;
  logic [1:0]        err_c;
  logic [PRBS_N-1:0] h_seed_c, h_pred_c;
  logic [ERR_SW-1:0] err_sum_c;
  logic              count_c;

  prbs_predict2 #(
    .N(PRBS_N),
    .M(TAP_M)
  ) u_pred (
    .h_i     (h_q),
    .din_i   (din_q),
    .pred_c  (pred_c),
    .h_seed_c(h_seed_c),
    .h_pred_c(h_pred_c)
  );

  assign miss_c    = pred_c ^ din_q;
  assign err_c     = {1'b0, miss_c[1]} + {1'b0, miss_c[0]};
  assign err_sum_c = {1'b0, err_q} + ERR_SW'(err_c);

  // Next-state, history and counter update; processing is qualified by the latched EN.
  always_comb begin
    state_d = state_q;
    din_d   = EN ? DIN : din_q;
    en_d    = EN;
    h_d     = h_q;
    seed_d  = seed_q;
    recv_d  = recv_q;
    err_d   = err_q;
    count_c = 1'b0;
`ifdef PRBS_LOCK_EN
    run_d   = run_q;
    loss_d  = loss_q;
`endif

    if (CLR) begin
      state_d = ST_SEED;
      din_d   = din_q;
      en_d    = 1'b0;
      h_d     = '0;
      seed_d  = '0;
      recv_d  = '0;
      err_d   = '0;
`ifdef PRBS_LOCK_EN
      run_d   = '0;
      loss_d  = '0;
`endif
    end else if (en_q) begin
      case (state_q)
        ST_SEED: begin
          h_d = h_seed_c;
          if (seed_q == SEED_W'(SEED_LEN - 1)) begin
            seed_d = '0;
`ifdef PRBS_LOCK_EN
            state_d = ST_HUNT;
            run_d   = '0;
            loss_d  = '0;
`else
            state_d = ST_CHECK;
`endif
          end else begin
            seed_d = seed_q + SEED_W'(1);
          end
        end
        default: begin
          if (h_q == '0) begin
            state_d = ST_SEED;
            seed_d  = '0;
          end else begin
            h_d = h_pred_c;
`ifdef PRBS_LOCK_EN
            if (state_q == ST_HUNT) begin
              if (err_c != 2'd0) begin
                state_d = ST_SEED;
                run_d   = '0;
              end else if (run_q == RUN_W'(LOCK_CNT - 1)) begin
                state_d = ST_LOCK;
                run_d   = '0;
              end else begin
                run_d = run_q + RUN_W'(1);
              end
            end else begin
              count_c = 1'b1;
              if (err_c == 2'd0) begin
                loss_d = '0;
              end else if (loss_q == LOSS_W'(LOSS_CNT - 1)) begin
                state_d = ST_SEED;
                loss_d  = '0;
              end else begin
                loss_d = loss_q + LOSS_W'(1);
              end
            end
`else
            count_c = 1'b1;
`endif
          end
        end
      endcase
    end

    // Counters saturate at all-ones and stay there until cleared.
    if (count_c) begin
      recv_d = (recv_q >= RECV_MAX - RECV_W'(1)) ? RECV_MAX : recv_q + RECV_W'(2);
      err_d  = err_sum_c[ERR_W] ? ERR_MAX : err_sum_c[ERR_W-1:0];
    end

    sat_d = (recv_d == RECV_MAX) | (err_d == ERR_MAX);
`ifdef PRBS_LOCK_EN
    locked_d = (state_d == ST_LOCK);
`else
    locked_d = (state_d == ST_CHECK);
`endif
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      state_q  <= ST_SEED;
      din_q    <= '0;
      en_q     <= 1'b0;
      h_q      <= '0;
      seed_q   <= '0;
      recv_q   <= '0;
      err_q    <= '0;
      sat_q    <= 1'b0;
      locked_q <= 1'b0;
`ifdef PRBS_LOCK_EN
      run_q    <= '0;
      loss_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      din_q    <= din_d;
      en_q     <= en_d;
      h_q      <= h_d;
      seed_q   <= seed_d;
      recv_q   <= recv_d;
      err_q    <= err_d;
      sat_q    <= sat_d;
      locked_q <= locked_d;
`ifdef PRBS_LOCK_EN
      run_q    <= run_d;
      loss_q   <= loss_d;
`endif
    end
  end

  assign RECV_CNT = recv_q;
  assign ERR_CNT  = err_q;
  assign LOCKED   = locked_q;
  assign SAT      = sat_q;

endmodule

// File: tb/tb_prbs_ber_checker.sv
// Scoreboard bench for prbs_ber_checker: full-width instance plus a narrow one for saturation.
module tb_prbs_ber_checker;

  localparam int unsigned N   = 7;
  localparam int unsigned M   = 6;
  localparam int unsigned RWA = 58;
  localparam int unsigned EWA = 64;
  localparam int unsigned RWB = 6;
  localparam int unsigned EWB = 3;

  logic           CLK  = 1'b0;
  logic           RSTX = 1'b0;
  logic           CLR  = 1'b0;
  logic           EN   = 1'b0;
  logic [1:0]     DIN  = 2'b00;
  logic [RWA-1:0] recv_a;
  logic [EWA-1:0] err_a;
  logic           locked_a, sat_a;
  logic [RWB-1:0] recv_b;
  logic [EWB-1:0] err_b;
  logic           locked_b, sat_b;

  prbs_ber_checker #(.PRBS_N(N), .RECV_W(RWA), .ERR_W(EWA)) dut (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .EN(EN), .DIN(DIN),
    .RECV_CNT(recv_a), .ERR_CNT(err_a), .LOCKED(locked_a), .SAT(sat_a)
  );

  prbs_ber_checker #(.PRBS_N(N), .RECV_W(RWB), .ERR_W(EWB)) dut_s (
    .CLK(CLK), .RSTX(RSTX), .CLR(CLR), .EN(EN), .DIN(DIN),
    .RECV_CNT(recv_b), .ERR_CNT(err_b), .LOCKED(locked_b), .SAT(sat_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    longint unsigned recv;
    longint unsigned err;
    bit              locked;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   running = 1'b0;

  bit gen_hist[$];
  bit m_hist[$];
  bit m_seeding;
  int m_seed_cnt;
  bit m_en_p;
  logic [1:0] m_din_p;
  longint unsigned m_recv, m_err;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 20) $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned clamp(input longint unsigned v, input int unsigned w);
    longint unsigned mx;
    mx = (w >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
    return (v > mx) ? mx : v;
  endfunction

  // Stream source: b[n] = b[n-7] ^ b[n-6], oldest bit at index 0.
  function automatic bit gen_bit();
    bit b;
    b = gen_hist[0] ^ gen_hist[N-M];
    gen_hist.push_back(b);
    void'(gen_hist.pop_front());
    return b;
  endfunction

  function automatic bit model_predict();
    bit b;
    b = m_hist[0] ^ m_hist[N-M];
    m_hist.push_back(b);
    void'(m_hist.pop_front());
    return b;
  endfunction

  function automatic void model_clear_hist();
    m_hist.delete();
    for (int i = 0; i < int'(N); i++) m_hist.push_back(1'b0);
  endfunction

  function automatic bit model_hist_zero();
    for (int i = 0; i < m_hist.size(); i++) if (m_hist[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Reference model: one step per clock edge, then the post-edge expectation is queued.
  always @(posedge CLK) begin
    if (running) begin
      exp_t e;
      bit p1, p0;
      if (CLR) begin
        m_recv = 0; m_err = 0; m_seeding = 1'b1; m_seed_cnt = 0; m_en_p = 1'b0;
        model_clear_hist();
      end else begin
        if (m_en_p) begin
          if (m_seeding) begin
            m_hist.push_back(m_din_p[1]); void'(m_hist.pop_front());
            m_hist.push_back(m_din_p[0]); void'(m_hist.pop_front());
            m_seed_cnt++;
            if (m_seed_cnt == int'((N + 1) / 2)) begin
              m_seeding = 1'b0;
              m_seed_cnt = 0;
            end
          end else if (model_hist_zero()) begin
            m_seeding = 1'b1;
          end else begin
            p1 = model_predict();
            p0 = model_predict();
            m_recv += 2;
            m_err  += longint'(p1 != m_din_p[1]) + longint'(p0 != m_din_p[0]);
          end
        end
        m_en_p = EN;
        if (EN) m_din_p = DIN;
      end
      e.recv = m_recv; e.err = m_err; e.locked = !m_seeding;
      exp_q.push_back(e);
    end
  end

  // Monitor: compares both instances every cycle against the oldest queued expectation.
  always @(negedge CLK) begin
    if (exp_q.size() > 2) begin
      check("scoreboard_depth", 64'(exp_q.size()), 64'd1);
      exp_q.delete();
    end else if (exp_q.size() > 0) begin
      exp_t e;
      longint unsigned rb, eb;
      e  = exp_q.pop_front();
      rb = clamp(e.recv, RWB);
      eb = clamp(e.err, EWB);
      check("recv_a", 64'(recv_a), clamp(e.recv, RWA));
      check("err_a", 64'(err_a), clamp(e.err, EWA));
      check("locked_a", 64'(locked_a), 64'(e.locked));
      check("sat_a", 64'(sat_a),
            64'((clamp(e.recv, RWA) == clamp(64'hFFFF_FFFF_FFFF_FFFF, RWA)) || (e.err == 64'hFFFF_FFFF_FFFF_FFFF)));
      check("recv_b", 64'(recv_b), rb);
      check("err_b", 64'(err_b), eb);
      check("locked_b", 64'(locked_b), 64'(e.locked));
      check("sat_b", 64'(sat_b), 64'((rb == 64'd63) || (eb == 64'd7)));
    end
  end

  // mode 0: PRBS stream, 1: random data, 2: constant zeros
  task automatic step(input bit en, input bit clr, input logic [1:0] flip, input int mode);
    bit b1, b0;
    @(posedge CLK);
    #1;
    EN  = en;
    CLR = clr;
    if (mode == 2) DIN = 2'b00;
    else if (mode == 1) DIN = 2'($urandom);
    else if (en) begin
      b1 = gen_bit();
      b0 = gen_bit();
      DIN = {b1, b0} ^ flip;
    end
  endtask

  task automatic run_clean(input int n, input int en_pct);
    for (int i = 0; i < n; i++) step(($urandom_range(0, 99) < en_pct), 1'b0, 2'b00, 0);
  endtask

  initial begin
    for (int i = 0; i < int'(N); i++) gen_hist.push_back(1'b1);
    model_clear_hist();
    m_seeding = 1'b1; m_seed_cnt = 0; m_en_p = 1'b0; m_din_p = 2'b00;
    m_recv = 0; m_err = 0;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_recv", 64'(recv_a), 64'd0);
    check("rst_err", 64'(err_a), 64'd0);
    check("rst_locked", 64'(locked_a), 64'd0);
    check("rst_sat", 64'(sat_a), 64'd0);
    @(posedge CLK);
    #1;
    RSTX = 1'b1;
    running = 1'b1;

    // Clean stream: 4 samples seed the history, the remaining 996 are counted.
    run_clean(1000, 100);
    step(1'b0, 1'b0, 2'b00, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("t1_recv", 64'(recv_a), 64'd1992);
    check("t1_err", 64'(err_a), 64'd0);
    check("t1_locked", 64'(locked_a), 64'd1);
    check("t1_sat_small", 64'(sat_b), 64'd1);

    run_clean(50, 100);
    step(1'b1, 1'b0, 2'b10, 0);
    run_clean(100, 100);
    step(1'b1, 1'b0, 2'b11, 0);
    run_clean(100, 100);
    step(1'b0, 1'b0, 2'b00, 0);
    @(posedge CLK);
    @(negedge CLK);
    check("t2_err", 64'(err_a), 64'd3);
    check("t2_locked", 64'(locked_a), 64'd1);

    step(1'b1, 1'b1, 2'b00, 0);
    step(1'b0, 1'b0, 2'b00, 0);
    @(negedge CLK);
    check("t3_recv", 64'(recv_a), 64'd0);
    check("t3_err", 64'(err_a), 64'd0);
    check("t3_locked", 64'(locked_a), 64'd0);
    check("t3_sat_small", 64'(sat_b), 64'd0);
    run_clean(300, 100);

    run_clean(600, 50);
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, 2'b00, 1);

    step(1'b1, 1'b1, 2'b00, 2);
    for (int i = 0; i < 40; i++) step(1'b1, 1'b0, 2'b00, 2);

    step(1'b1, 1'b1, 2'b00, 0);
    run_clean(200, 100);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b00, 0);

    running = 1'b0;
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge CLK);
    @(posedge CLK);
    if (exp_q.size() != 0) check("scoreboard_drain", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
